// File: rtl/fifo_burst_reader_pkg.sv
// Shared constants and state encoding for the IMC input FIFO read-side controller.
// Word geometry matches sync_fifo_16x16.
package fifo_burst_reader_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int DATA_DEPTH = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int LEN_WIDTH  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Legal burst lengths are 1..DATA_DEPTH; anything else leaves the controller idle.
  function automatic logic len_ok(input logic [LEN_WIDTH-1:0] len);
    return (len != '0) && (len <= LEN_WIDTH'(DATA_DEPTH));
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Word stream from the burst reader to the IMC row loader.
// A word transfers on a cycle where m_valid and m_ready are both high; once m_valid rises,
// m_valid, m_data and m_last hold steady until that transfer, and m_ready may change freely.
interface fifo_burst_reader_if;
  import fifo_burst_reader_pkg::*;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input  m_ready);
  modport slave  (input  m_valid, input  m_data, input  m_last, output m_ready);

endinterface

// File: rtl/fifo_burst_reader_skid_buf_2.sv
// Two-entry in-order buffer between the FIFO read data and the output stream.
// Slot 0 is always the head; a pop shifts slot 1 forward.
module fifo_burst_reader_skid_buf_2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       occ_q, occ_d;
  logic [1:0]       fill;
  logic             pop;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = slot0_q;
  assign occupancy = occ_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    // Entries left after this cycle's pop decide where an incoming word lands.
    fill    = occ_q - {1'b0, pop};
    if (pop) begin
      slot0_d = slot1_q;
    end
    if (push) begin
      if (fill == 2'd0) begin
        slot0_d = push_data;
      end else begin
        slot1_d = push_data;
      end
    end
    occ_d = fill + {1'b0, push};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller: owns the FIFO read pointer, issues reads against a two-word
// credit, absorbs the FIFO's one-cycle read latency and streams words out with last/done.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    burst_len,
  input  logic                    fifo_empty,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  output logic                    fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]   fifo_rd_addr,
  fifo_burst_reader_if.master     m,
  output logic                    busy,
  output logic                    done
);

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [1:0]            occupancy;
  logic                  skid_valid;
  logic                  pop;
  logic                  credit_ok;
  logic                  rd_en;

  fifo_burst_reader_skid_buf_2 #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (fifo_data),
    .out_valid (skid_valid),
    .out_ready (m.m_ready),
    .out_data  (m.m_data),
    .occupancy (occupancy)
  );

  assign m.m_valid    = skid_valid;
  assign m.m_last     = skid_valid & (beat_cnt_q == LEN_WIDTH'(1));
  assign pop          = skid_valid & m.m_ready;
  assign fifo_rd_en   = rd_en;
  assign fifo_rd_addr = rd_ptr_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Buffered plus in-flight words, less the one leaving now, must stay below two.
  assign credit_ok = ({1'b0, occupancy} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign rd_en     = (state_q == ST_RUN) && (issue_cnt_q != '0) && !fifo_empty && credit_ok;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    rd_ptr_d    = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, rd_en};
    inflight_d  = rd_en;

    if (rd_en) begin
      issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
    end
    if (pop && (beat_cnt_q != '0)) begin
      beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start && len_ok(burst_len)) begin
          issue_cnt_d = burst_len;
          beat_cnt_d  = burst_len;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue_cnt_d == '0) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // The last beat can only leave after its read has landed, so inflight is clear here.
        if (beat_cnt_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural 16x16 FIFO and a data/address scoreboard.
module tb_fifo_burst_reader;
  import fifo_burst_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  burst_len = '0;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_rd_en;
  logic [3:0]  fifo_rd_addr;
  logic        busy, done;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;

  fifo_burst_reader_if s_if ();

  fifo_burst_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .burst_len    (burst_len),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_addr (fifo_rd_addr),
    .m            (s_if.master),
    .busy         (busy),
    .done         (done)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural FIFO storage: external read address, registered read data
  logic [15:0] mem [16];
  logic [3:0]  mdl_wptr;
  int          mdl_count;
  assign fifo_empty = (mdl_count == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_wptr  <= '0;
      mdl_count <= 0;
      fifo_data <= '0;
    end else begin
      if (wr_en) begin
        mem[mdl_wptr] <= wr_data;
        mdl_wptr      <= mdl_wptr + 4'd1;
      end
      if (fifo_rd_en) fifo_data <= mem[fifo_rd_addr];
      mdl_count <= mdl_count + int'(wr_en) - int'(fifo_rd_en);
    end
  end

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q  [$];
  logic [3:0]  addr_q [$];
  logic [15:0] late_q [$];
  logic [15:0] shadow [16];
  int          sh_ptr = 0;
  int          beats_left;

  int r_first_rd, r_last_rd, r_first_v, r_last_hs, r_done_c, r_ndone, r_hs, r_rd_lo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string pfx);
    check({pfx, "_m_valid"}, 32'(s_if.m_valid), 0);
    check({pfx, "_m_last"},  32'(s_if.m_last), 0);
    check({pfx, "_m_data"},  32'(s_if.m_data), 0);
    check({pfx, "_rd_en"},   32'(fifo_rd_en), 0);
    check({pfx, "_rd_addr"}, 32'(fifo_rd_addr), 0);
    check({pfx, "_busy"},    32'(busy), 0);
    check({pfx, "_done"},    32'(done), 0);
    check({pfx, "_state"},   32'(dut.state_q), 0);
  endtask

  // driver tasks
  task automatic fill(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = base + 16'(i);
      shadow[sh_ptr % 16] = base + 16'(i);
      sh_ptr++;
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic queue_late(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      late_q.push_back(base + 16'(i));
      shadow[sh_ptr % 16] = base + 16'(i);
      sh_ptr++;
    end
  endtask

  task automatic expect_burst(input int first_addr, input int len);
    for (int i = 0; i < len; i++) begin
      addr_q.push_back(4'((first_addr + i) % 16));
      exp_q.push_back(shadow[(first_addr + i) % 16]);
    end
  endtask

  task automatic run_burst(input int len, input int rdy_lo_from, input int rdy_lo_to,
                           input int late_delay, input int restart_cyc, input int abort_after);
    r_first_rd = -1; r_last_rd = -1; r_first_v = -1; r_last_hs = -1;
    r_done_c = -1; r_ndone = 0; r_hs = 0; r_rd_lo = 0;
    beats_left = len;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      start     = (c == 0) || (c == restart_cyc);
      burst_len = (c == 0) ? 5'(len) : 5'd4;
      s_if.m_ready = !((c >= rdy_lo_from) && (c <= rdy_lo_to));
      wr_en = 1'b0;
      if ((c >= late_delay) && (late_q.size() > 0)) begin
        wr_en   = 1'b1;
        wr_data = late_q.pop_front();
      end
      @(negedge clk);
      if (c == 1) check("busy_in_run", 32'(busy), 1);
      if (fifo_rd_en) begin
        if (r_first_rd < 0) r_first_rd = c;
        r_last_rd = c;
        if (!s_if.m_ready) r_rd_lo++;
        check("rd_while_empty", 32'(fifo_empty), 0);
        if (addr_q.size() > 0) check("rd_addr", 32'(fifo_rd_addr), 32'(addr_q.pop_front()));
        else check("extra_rd", 1, 0);
      end
      if (s_if.m_valid) begin
        if (r_first_v < 0) r_first_v = c;
        check("skid_credit", 32'(32'(dut.u_skid.occ_q) + 32'(dut.inflight_q) <= 2), 1);
        check("m_last", 32'(s_if.m_last), 32'(beats_left == 1));
      end
      if (s_if.m_valid && s_if.m_ready) begin
        if (exp_q.size() > 0) check("m_data", 32'(s_if.m_data), 32'(exp_q.pop_front()));
        else check("extra_beat", 1, 0);
        beats_left--;
        r_hs++;
        r_last_hs = c;
      end
      if (done) begin
        r_ndone++;
        r_done_c = c;
      end
      if ((abort_after > 0) && (r_hs == abort_after)) return;
      if ((r_done_c >= 0) && (c == r_done_c + 2)) break;
    end
    start = 1'b0; wr_en = 1'b0; s_if.m_ready = 1'b1;
    if (r_done_c < 0) check("burst_timeout", 0, 1);
    check("exp_q_drained", 32'(exp_q.size()), 0);
    check("addr_q_drained", 32'(addr_q.size()), 0);
    check("busy_after", 32'(busy), 0);
  endtask

  task automatic idle_cmd(input logic [4:0] len, input string tag);
    int rd_seen = 0, busy_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; burst_len = len;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      rd_seen   += int'(fifo_rd_en);
      busy_seen += int'(busy);
    end
    check({tag, "_rd"}, 32'(rd_seen), 0);
    check({tag, "_busy"}, 32'(busy_seen), 0);
  endtask

  initial begin
    s_if.m_ready = 1'b1;
    #12;
    chk_idle_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // basic burst of 4 from address 0
    fill(4, 16'h0000);
    expect_burst(0, 4);
    run_burst(4, 1000, 1000, 0, -1, 0);
    check("t1_first_rd", 32'(r_first_rd), 1);
    check("t1_rd_span", 32'(r_last_rd - r_first_rd), 3);
    check("t1_latency", 32'(r_first_v - r_first_rd), 2);
    check("t1_done_delay", 32'(r_done_c - r_last_hs), 1);
    check("t1_ndone", 32'(r_ndone), 1);
    check("t1_hs", 32'(r_hs), 4);

    // consume up to address 13, then a burst that wraps 14,15,0,1
    fill(10, 16'h0100);
    expect_burst(4, 10);
    run_burst(10, 1000, 1000, 0, -1, 0);
    check("t2a_hs", 32'(r_hs), 10);
    fill(4, 16'h0200);
    expect_burst(14, 4);
    run_burst(4, 1000, 1000, 0, -1, 0);
    check("t2_hs", 32'(r_hs), 4);
    check("t2_ptr_persist", 32'(fifo_rd_addr), 2);

    // backpressure in cycles 3..7: credits exhaust, no reads while stalled
    fill(8, 16'h0300);
    expect_burst(2, 8);
    run_burst(8, 3, 7, 0, -1, 0);
    check("t3_rd_while_lo", 32'(r_rd_lo), 0);
    check("t3_hs", 32'(r_hs), 8);
    check("t3_ndone", 32'(r_ndone), 1);

    // FIFO underflow: two words present, three more arrive 10 cycles into the burst
    fill(2, 16'h0400);
    queue_late(3, 16'h0402);
    expect_burst(10, 5);
    run_burst(5, 1000, 1000, 10, -1, 0);
    check("t4_hs", 32'(r_hs), 5);
    check("t4_ndone", 32'(r_ndone), 1);
    check("t4_stall_len", 32'(r_last_rd >= 11), 1);

    // ignored commands: illegal lengths, and a second start while busy
    fill(7, 16'h0500);
    idle_cmd(5'd0, "len0");
    idle_cmd(5'd17, "len17");
    expect_burst(15, 3);
    run_burst(3, 1000, 1000, 0, 2, 0);
    check("t5_hs", 32'(r_hs), 3);
    check("t5_ndone", 32'(r_ndone), 1);

    // reset after 3 of 8 words: everything clears, next burst starts at address 0
    fill(4, 16'h0600);
    expect_burst(2, 8);
    run_burst(8, 1000, 1000, 0, -1, 3);
    rst_n = 1'b0;
    #1;
    chk_idle_zero("midrst");
    check("midrst_ndone", 32'(r_ndone), 0);
    exp_q.delete(); addr_q.delete(); late_q.delete();
    start = 1'b0; wr_en = 1'b0; s_if.m_ready = 1'b1;
    sh_ptr = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("midrst_no_done", 32'(done), 0);
    rst_n = 1'b1;
    fill(2, 16'h0700);
    expect_burst(0, 2);
    run_burst(2, 1000, 1000, 0, -1, 0);
    check("t6_first_rd", 32'(r_first_rd), 1);
    check("t6_hs", 32'(r_hs), 2);
    check("t6_ndone", 32'(r_ndone), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "time limit");
  end

endmodule
